fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'hBFC0_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-low reset sampled on the clk rising edge.
REQ-004 The block SHALL have port stall_f, input, 1, hold the current PC and instruction (decode not accepting).
REQ-005 The block SHALL have port redirect, input, 1, taken branch or jump: load redirect_pc.
REQ-006 The block SHALL have port redirect_pc, input, 32, redirect target address.
REQ-007 The block SHALL have port imem_req, output, 1, instruction memory request, level-held until response.
REQ-008 The block SHALL have port imem_addr, output, 32, word-aligned fetch address, equal to pc_f.
REQ-009 The block SHALL have port imem_rvalid, input, 1, response strobe, may assert in the same cycle as imem_req or later.
REQ-010 The block SHALL have port imem_rdata, input, 32, instruction word, valid only with imem_rvalid.
REQ-011 The block SHALL have port pc_f, output, 32, address of the instruction being fetched.
REQ-012 The block SHALL have port pc_plus_4_f, output, 32, pc_f + 4, which feeds the decode pipeline register.
REQ-013 The block SHALL have port instr_f, output, 32, fetched instruction presented to the decode register.
REQ-014 The block SHALL have port instr_valid_f, output, 1, instr_f valid this cycle.
REQ-015 The block SHALL have port fetch_busy, output, 1, equal to ~instr_valid_f, so the hazard unit inserts a decode bubble (flush_d).

Function
REQ-016 The block SHALL implement a three-state FSM: FETCH (request outstanding), HOLD (instruction buffered under stall), DRAIN (discarding a stale response).
REQ-017 In FETCH, the block SHALL drive imem_req=1 and imem_addr=pc_f, and SHALL keep both stable until imem_rvalid.
REQ-018 In FETCH with imem_rvalid=1, the block SHALL drive instr_f=imem_rdata and instr_valid_f=1 combinationally in the same cycle.
REQ-019 In FETCH with imem_rvalid=1, stall_f=0 and redirect=0, the block SHALL update pc_f<=pc_f+4 and stay in FETCH, giving one instruction per cycle with a zero-wait memory.
REQ-020 In FETCH with imem_rvalid=1, stall_f=1 and redirect=0, the block SHALL capture imem_rdata into the hold buffer, keep pc_f, and go to HOLD.
REQ-021 In FETCH with imem_rvalid=0, the block SHALL drive instr_valid_f=0 and SHALL leave pc_f and the state unchanged.
REQ-022 In HOLD, the block SHALL drive imem_req=0, instr_f=buffer and instr_valid_f=1.
REQ-023 In HOLD, when stall_f=0 and redirect=0, the block SHALL update pc_f<=pc_f+4 and go to FETCH.
REQ-024 Redirect SHALL have priority over stall_f and over memory response: pc_f<=redirect_pc with bits[1:0] forced to 0, and the hold buffer is discarded.
REQ-025 A redirect in FETCH with imem_rvalid=0 SHALL transition to DRAIN, because a request is outstanding.
REQ-026 A redirect in FETCH with imem_rvalid=1, or in HOLD, SHALL transition to FETCH, and the response SHALL be dropped.
REQ-027 In DRAIN, the block SHALL drive imem_req=0 and instr_valid_f=0.
REQ-028 In DRAIN, the next imem_rvalid SHALL be discarded and the state SHALL go to FETCH.
REQ-029 A redirect in DRAIN SHALL update pc_f and remain in DRAIN.
REQ-030 pc_plus_4_f SHALL be pc_f+4 modulo 2^32, so that 32'hFFFF_FFFC gives 32'h0000_0000.
REQ-031 While instr_valid_f=0, the block SHALL drive instr_f to 32'h0000_0000, which is a NOP.

Reset
REQ-032 While rst=0 at a clock edge, the next state SHALL be: pc_f=RESET_PC, state=FETCH, hold buffer=0.
REQ-033 During the reset cycle, the block SHALL drive imem_req=0, instr_valid_f=0 and instr_f=0.
REQ-034 A reset asserted with a request outstanding SHALL NOT drain the stale response; the memory side is reset in the same cycle.
REQ-035 The first imem_req SHALL assert in the first cycle with rst=1.

Verification
REQ-036 Zero-wait memory, rvalid tied 1, 4 cycles after reset -> pc_f = BFC0_0000, _0004, _0008, _000C; instr_valid_f=1 each cycle.
REQ-037 rvalid delayed 3 cycles -> imem_addr stable for 3 cycles; fetch_busy=1 for 2 cycles then 0; pc_f advances once.
REQ-038 rvalid=1 with data 32'h2408_0005 and stall_f=1 for 2 cycles -> HOLD; instr_f=2408_0005 throughout; imem_req=0; pc_f advances only after stall_f drops.
REQ-039 redirect to 32'h0040_0013 while a request is pending, then rvalid 2 cycles later with data 32'hDEAD_BEEF -> DEAD_BEEF never appears with instr_valid_f=1; next imem_addr=0040_0010.
REQ-040 redirect and stall_f together in HOLD -> pc_f=redirect_pc; state FETCH; buffer discarded.
REQ-041 rst=0 mid-DRAIN -> next cycle pc_f=RESET_PC, state FETCH, instr_valid_f=0; RESET_PC=32'hFFFF_FFFC gives pc_plus_4_f=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Request is level-held until imem_rvalid; the response may arrive in the same cycle.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: zero extra latency (imem_rdata is forwarded combinationally);
// stall_f parks the fetched word in a hold buffer, and a redirect drains any stale response.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_f,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   fetch_stage_if.master        imem,
   output logic [31:0]          pc_f,
   output logic [31:0]          pc_plus_4_f,
   output logic [31:0]          instr_f,
   output logic                 instr_valid_f,
   output logic                 fetch_busy
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] pc_d;
   logic [31:0] hold_q;
   logic [31:0] hold_d;
   logic        req;
   logic        vld;
   logic [31:0] instr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FETCH;
         pc_f    <= RESET_PC;
         hold_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_f    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_f;
      hold_d  = hold_q;
      req     = 1'b0;
      vld     = 1'b0;
      instr   = 32'h0000_0000;

      case (state_q)
         FETCH: begin
            req = 1'b1;
            if (imem.imem_rvalid) begin
               vld   = 1'b1;
               instr = imem.imem_rdata;
            end
            if (redirect) begin
               state_d = imem.imem_rvalid ? FETCH : DRAIN;
            end else if (imem.imem_rvalid) begin
               if (stall_f) begin
                  hold_d  = imem.imem_rdata;
                  state_d = HOLD;
               end else begin
                  pc_d = pc_f + 32'd4;
               end
            end
         end
         HOLD: begin
            vld   = 1'b1;
            instr = hold_q;
            if (redirect || !stall_f) begin
               state_d = FETCH;
               pc_d    = pc_f + 32'd4;
            end
         end
         DRAIN: begin
            // A response landing together with a redirect still retires the stale request.
            if (imem.imem_rvalid) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      if (redirect) begin
         pc_d   = {redirect_pc[31:2], 2'b00};
         hold_d = 32'h0000_0000;
      end

      if (!rst) begin
         req   = 1'b0;
         vld   = 1'b0;
         instr = 32'h0000_0000;
      end
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_f;
   assign instr_f        = instr;
   assign instr_valid_f  = vld;
   assign fetch_busy     = ~vld;
   assign pc_plus_4_f    = pc_f + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized fetch-stage bench with a transaction-level reference model and a
// variable-latency instruction memory; directed sequences pin the model to literal values.
module tb_fetch_stage;
   localparam logic [31:0] RPC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_f;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc_f, pc_plus_4_f, instr_f;
   logic        instr_valid_f, fetch_busy;

   logic [31:0] pc2, pc_plus_4_2, instr2;
   logic        valid2, busy2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_stage_if imem();
   fetch_stage_if imem2();

   assign imem2.imem_rvalid = 1'b1;
   assign imem2.imem_rdata  = 32'h0000_0000;

   fetch_stage #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall_f(stall_f), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem(imem), .pc_f(pc_f),
      .pc_plus_4_f(pc_plus_4_f), .instr_f(instr_f),
      .instr_valid_f(instr_valid_f), .fetch_busy(fetch_busy)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst), .stall_f(1'b0), .redirect(1'b0),
      .redirect_pc(32'h0000_0000), .imem(imem2), .pc_f(pc2),
      .pc_plus_4_f(pc_plus_4_2), .instr_f(instr2),
      .instr_valid_f(valid2), .fetch_busy(busy2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Memory model: one request in flight, latency chosen when the request is first seen.
   bit          mem_busy = 1'b0;
   int          mem_cnt  = 0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_data = 32'h0;
   int          force_lat = 0;
   bit          force_data_en = 1'b0;
   logic [31:0] force_data = 32'h0;

   // Reference model: current PC, optional buffered word, and whether an abandoned request is owed.
   logic [31:0] m_pc = RPC;
   logic [31:0] m_buf = 32'h0;
   bit          m_has_buf = 1'b0;
   bit          m_stale = 1'b0;

   task automatic step(input logic r, input logic s, input logic d, input logic [31:0] p);
      @(posedge clk);
      #1;
      rst = r; stall_f = s; redirect = d; redirect_pc = p;
      #1;
      if (!rst) begin
         imem.imem_rvalid = 1'b0;
         imem.imem_rdata  = $urandom;
      end else begin
         if (imem.imem_req && !mem_busy) begin
            mem_busy = 1'b1;
            mem_cnt  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            mem_addr = imem.imem_addr;
            mem_data = force_data_en ? force_data : mem_fn(imem.imem_addr);
         end
         imem.imem_rvalid = mem_busy && (mem_cnt == 0);
         imem.imem_rdata  = imem.imem_rvalid ? mem_data : $urandom;
      end
   endtask

   always @(posedge clk) begin
      bit exp_req;
      if (!rst) begin
         mem_busy  = 1'b0;
         m_pc      = RPC;
         m_buf     = 32'h0;
         m_has_buf = 1'b0;
         m_stale   = 1'b0;
      end else begin
         if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 1'b0;
            else mem_cnt--;
         end
         exp_req = !m_has_buf && !m_stale;
         if (redirect) begin
            m_stale   = (m_stale || exp_req) && !imem.imem_rvalid;
            m_has_buf = 1'b0;
            m_pc      = redirect_pc & 32'hFFFF_FFFC;
         end else if (m_stale) begin
            if (imem.imem_rvalid) m_stale = 1'b0;
         end else if (m_has_buf) begin
            if (!stall_f) begin
               m_has_buf = 1'b0;
               m_pc      = m_pc + 32'd4;
            end
         end else if (imem.imem_rvalid) begin
            if (stall_f) begin
               m_has_buf = 1'b1;
               m_buf     = imem.imem_rdata;
            end else begin
               m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit          e_req, e_vld;
      logic [31:0] e_instr;
      e_req   = rst && !m_has_buf && !m_stale;
      e_vld   = rst && (m_has_buf || (e_req && imem.imem_rvalid));
      e_instr = !e_vld ? 32'h0 : (m_has_buf ? m_buf : imem.imem_rdata);
      chk("model_req",   32'(imem.imem_req), 32'(e_req));
      chk("model_addr",  imem.imem_addr, m_pc);
      chk("model_pc",    pc_f, m_pc);
      chk("model_pc4",   pc_plus_4_f, m_pc + 32'd4);
      chk("model_valid", 32'(instr_valid_f), 32'(e_vld));
      chk("model_instr", instr_f, e_instr);
      chk("model_busy",  32'(fetch_busy), 32'(!e_vld));
      if (rst && imem.imem_req && mem_busy)
         chk("addr_stable", imem.imem_addr, mem_addr);
   end

   initial begin
      rst = 1'b0; stall_f = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;

      // Reset cycle and zero-wait streaming
      force_lat = 0;
      step(0, 0, 0, 0);
      @(negedge clk);
      chk("rst_req",   32'(imem.imem_req), 32'h0);
      chk("rst_valid", 32'(instr_valid_f), 32'h0);
      chk("rst_instr", instr_f, 32'h0);
      chk("rst_pc",    pc_f, RPC);
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 0, 0);
         @(negedge clk);
         chk("zw_pc",    pc_f, RPC + 32'(4 * k));
         chk("zw_valid", 32'(instr_valid_f), 32'h1);
         if (k == 0) begin
            chk("wrap_pc",  pc2, 32'hFFFF_FFFC);
            chk("wrap_pc4", pc_plus_4_2, 32'h0000_0000);
         end else if (k == 1) begin
            chk("wrap_pc_next",  pc2, 32'h0000_0000);
            chk("wrap_pc4_next", pc_plus_4_2, 32'h0000_0004);
         end
      end

      // Delayed response: address held, busy for two cycles, one advance
      force_lat = 2;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         @(negedge clk);
         chk("slow_addr", imem.imem_addr, 32'hBFC0_0010);
         chk("slow_busy", 32'(fetch_busy), (i < 2) ? 32'h1 : 32'h0);
      end
      force_lat = 0;
      step(1, 0, 0, 0);
      @(negedge clk);
      chk("slow_pc", pc_f, 32'hBFC0_0014);

      // Stall into the hold buffer
      force_data_en = 1'b1; force_data = 32'h2408_0005;
      step(1, 1, 0, 0);
      @(negedge clk);
      chk("hold_instr0", instr_f, 32'h2408_0005);
      chk("hold_valid0", 32'(instr_valid_f), 32'h1);
      step(1, 1, 0, 0);
      @(negedge clk);
      chk("hold_instr1", instr_f, 32'h2408_0005);
      chk("hold_req",    32'(imem.imem_req), 32'h0);
      chk("hold_pc",     pc_f, 32'hBFC0_0018);
      force_data_en = 1'b0;
      step(1, 0, 0, 0);
      @(negedge clk);
      chk("hold_instr2", instr_f, 32'h2408_0005);
      chk("hold_pc2",    pc_f, 32'hBFC0_0018);
      step(1, 0, 0, 0);
      @(negedge clk);
      chk("hold_release_pc",  pc_f, 32'hBFC0_001C);
      chk("hold_release_req", 32'(imem.imem_req), 32'h1);

      // Redirect with a request pending; stale DEAD_BEEF must be swallowed
      force_lat = 2; force_data_en = 1'b1; force_data = 32'hDEAD_BEEF;
      step(1, 0, 1, 32'h0040_0013);
      @(negedge clk);
      chk("drain_valid0", 32'(instr_valid_f), 32'h0);
      force_data_en = 1'b0;
      step(1, 0, 0, 0);
      @(negedge clk);
      chk("drain_req", 32'(imem.imem_req), 32'h0);
      chk("drain_pc",  pc_f, 32'h0040_0010);
      force_lat = 0;
      step(1, 0, 0, 0);
      @(negedge clk);
      chk("drain_valid2", 32'(instr_valid_f), 32'h0);
      chk("drain_instr2", instr_f, 32'h0000_0000);
      step(1, 0, 0, 0);
      @(negedge clk);
      chk("drain_next_addr",  imem.imem_addr, 32'h0040_0010);
      chk("drain_next_req",   32'(imem.imem_req), 32'h1);
      chk("drain_next_instr", instr_f, mem_fn(32'h0040_0010));

      // Redirect together with stall while holding
      step(1, 1, 0, 0);
      @(negedge clk);
      chk("rh_fill", instr_f, mem_fn(32'h0040_0014));
      step(1, 1, 1, 32'h0000_1000);
      @(negedge clk);
      chk("rh_valid", 32'(instr_valid_f), 32'h1);
      chk("rh_req",   32'(imem.imem_req), 32'h0);
      step(1, 1, 0, 0);
      @(negedge clk);
      chk("rh_pc",    pc_f, 32'h0000_1000);
      chk("rh_req2",  32'(imem.imem_req), 32'h1);
      chk("rh_instr", instr_f, mem_fn(32'h0000_1000));
      step(1, 0, 0, 0);
      @(negedge clk);
      chk("rh_newbuf", instr_f, mem_fn(32'h0000_1000));

      // Reset in the middle of a drain
      force_lat = 3;
      step(1, 0, 1, 32'h0000_2000);
      step(1, 0, 0, 0);
      @(negedge clk);
      chk("rd_drain_req", 32'(imem.imem_req), 32'h0);
      step(0, 0, 0, 0);
      @(negedge clk);
      chk("rd_rst_req",   32'(imem.imem_req), 32'h0);
      chk("rd_rst_valid", 32'(instr_valid_f), 32'h0);
      step(0, 0, 0, 0);
      @(negedge clk);
      chk("rd_pc",    pc_f, RPC);
      chk("rd_valid", 32'(instr_valid_f), 32'h0);
      force_lat = 1;
      step(1, 0, 0, 0);
      @(negedge clk);
      chk("rd_first_req",   32'(imem.imem_req), 32'h1);
      chk("rd_first_pc",    pc_f, RPC);
      chk("rd_first_valid", 32'(instr_valid_f), 32'h0);

      // Randomized traffic
      force_lat = -1;
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 30),
              ($urandom_range(0, 99) < 10), $urandom);
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
